// File: rtl/bsg_mem_1r1w_sync_from_1rw_pkg.sv
// Shared helpers for the 1R1W-from-1RW memory wrapper.
package bsg_mem_1r1w_sync_from_1rw_pkg;

    // Width needed to index n things; never returns 0 so single-entry cases still get a 1-bit field.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w_sync_from_1rw_wbuf.sv
// Write buffer: FIFO of {addr,data} with a youngest-match CAM for read forwarding.
// Optional in-place coalescing of same-address writes under BSG_MEM_WBUF_COALESCE_EN.
module bsg_mem_1r1w_sync_from_1rw_wbuf
    import bsg_mem_1r1w_sync_from_1rw_pkg::*;
#(
    parameter int width_p      = 8,
    parameter int addr_width_p = 4,
    parameter int els_p        = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_w_v,
    input  logic [addr_width_p-1:0] i_w_addr,
    input  logic [width_p-1:0]      i_w_data,
    input  logic                    i_pop,
    input  logic [addr_width_p-1:0] i_r_addr,
    output logic                    o_r_match,
    output logic [width_p-1:0]      o_r_data,
    output logic                    o_w_hit,
    output logic [addr_width_p-1:0] o_head_addr,
    output logic [width_p-1:0]      o_head_data,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = safe_clog2(els_p + 1);

    logic [addr_width_p-1:0] r_addr_mem [els_p];
    logic [width_p-1:0]      r_data_mem [els_p];
    logic [ptr_w_lp-1:0]     r_head;
    logic [ptr_w_lp-1:0]     r_tail;
    logic [cnt_w_lp-1:0]     r_count;
    logic                    w_alloc;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Slot holding the entry that is `age` positions younger than the head.
    function automatic logic [ptr_w_lp-1:0] age_slot(input logic [ptr_w_lp-1:0] head, input int age);
        int s;
        s = int'(head) + age;
        if (s >= els_p) s = s - els_p;
        return ptr_w_lp'(s);
    endfunction

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == cnt_w_lp'(els_p));
    assign o_head_addr = r_addr_mem[r_head];
    assign o_head_data = r_data_mem[r_head];

    // Scan oldest to youngest so the last hit is the youngest match.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        o_r_match = 1'b0;
        o_r_data  = '0;
        for (int i = 0; i < els_p; i++) begin
            if (i < int'(r_count) && r_addr_mem[age_slot(r_head, i)] == i_r_addr) begin
                o_r_match = 1'b1;
                o_r_data  = r_data_mem[age_slot(r_head, i)];
            end
        end
    end

`ifdef BSG_MEM_WBUF_COALESCE_EN
    logic                w_hit_any;
    logic [ptr_w_lp-1:0] w_hit_slot;
    logic                w_coalesce;

    always_comb begin
        w_hit_any  = 1'b0;
        w_hit_slot = '0;
        for (int i = 0; i < els_p; i++) begin
            if (i < int'(r_count) && r_addr_mem[age_slot(r_head, i)] == i_w_addr) begin
                w_hit_any  = 1'b1;
                w_hit_slot = age_slot(r_head, i);
            end
        end
    end

    // A hit on the head that is draining this cycle would be lost, so it allocates instead.
    assign o_w_hit    = w_hit_any && !(i_pop && w_hit_slot == r_head);
    assign w_coalesce = i_w_v && o_w_hit;
`else
    assign o_w_hit    = 1'b0;
`endif

    assign w_alloc = i_w_v && !o_w_hit;

    always_ff @(posedge i_clk) begin
        if (w_alloc) begin
            r_addr_mem[r_tail] <= i_w_addr;
            r_data_mem[r_tail] <= i_w_data;
        end
`ifdef BSG_MEM_WBUF_COALESCE_EN
        if (w_coalesce) begin
            r_data_mem[w_hit_slot] <= i_w_data;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_pop)   r_head <= next_ptr(r_head);
            if (w_alloc) r_tail <= next_ptr(r_tail);
            if (w_alloc && !i_pop)      r_count <= r_count + 1'b1;
            else if (!w_alloc && i_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/bsg_mem_1rw_sync.sv
// Behavioral single-port synchronous RAM: one read or one write per cycle, read data one cycle later.
module bsg_mem_1rw_sync
    import bsg_mem_1r1w_sync_from_1rw_pkg::*;
#(
    parameter  int width_p       = 8,
    parameter  int els_p         = 16,
    parameter  int harden_p      = 0,
    localparam int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic                     v_i,
    input  logic                     w_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] r_mem [els_p];
    logic [width_p-1:0] r_data;
    logic               w_unused_harden;

    // Only the behavioral model exists here; a hardened macro would be selected by harden_p.
    assign w_unused_harden = (harden_p != 0);

    // NOTE: storage arrays are deliberately not reset so they map onto real SRAM/BRAM.
    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            r_mem[addr_i] <= data_i;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_data <= '0;
        end else if (v_i && !w_i) begin
            r_data <= r_mem[addr_i];
        end
    end

    assign data_o = r_data;

endmodule

// File: rtl/bsg_mem_1r1w_sync_from_1rw.sv
// 1R1W synchronous memory built from one 1RW RAM plus a write buffer; reads always own the RAM port.
// Build option: BSG_MEM_WBUF_COALESCE_EN merges writes to an already-buffered address.
module bsg_mem_1r1w_sync_from_1rw
    import bsg_mem_1r1w_sync_from_1rw_pkg::*;
#(
    parameter  int width_p           = 8,
    parameter  int els_p             = 16,
    parameter  int wbuf_els_p        = 2,
    parameter  int latch_last_read_p = 0,
    parameter  int harden_p          = 0,
    localparam int addr_width_lp     = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    output logic                     w_ready_o,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o,
    output logic                     wbuf_empty_o
);

    logic                     w_full;
    logic                     w_empty;
    logic                     w_hit;
    logic                     w_drain;
    logic                     w_direct;
    logic                     w_buf_wr;
    logic                     w_r_match;
    logic [width_p-1:0]       w_r_fwd_data;
    logic [addr_width_lp-1:0] w_head_addr;
    logic [width_p-1:0]       w_head_data;
    logic                     w_ram_v;
    logic [addr_width_lp-1:0] w_ram_addr;
    logic [width_p-1:0]       w_ram_wdata;
    logic [width_p-1:0]       w_ram_rdata;
    logic [width_p-1:0]       w_read_data;
    logic                     r_fwd_sel;
    logic [width_p-1:0]       r_fwd_data;
    logic [16:0]              r_stall_cnt;

    // Priority: read, then drain the oldest buffered write, then a write straight into an empty buffer's place.
    assign w_drain      = !r_v_i && !w_empty;
    assign w_direct     = !r_v_i && w_empty && w_v_i;
    assign w_ready_o    = !w_full || w_drain || w_hit;
    assign w_buf_wr     = w_v_i && w_ready_o && !w_direct;
    assign wbuf_empty_o = w_empty;

    assign w_ram_v     = r_v_i || w_drain || w_direct;
    assign w_ram_addr  = r_v_i ? r_addr_i : (w_drain ? w_head_addr : w_addr_i);
    assign w_ram_wdata = w_drain ? w_head_data : w_data_i;

    bsg_mem_1r1w_sync_from_1rw_wbuf #(
        .width_p      (width_p),
        .addr_width_p (addr_width_lp),
        .els_p        (wbuf_els_p)
    ) u_wbuf (
        .i_clk       (clk_i),
        .i_reset     (reset_i),
        .i_w_v       (w_buf_wr),
        .i_w_addr    (w_addr_i),
        .i_w_data    (w_data_i),
        .i_pop       (w_drain),
        .i_r_addr    (r_addr_i),
        .o_r_match   (w_r_match),
        .o_r_data    (w_r_fwd_data),
        .o_w_hit     (w_hit),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    bsg_mem_1rw_sync #(
        .width_p  (width_p),
        .els_p    (els_p),
        .harden_p (harden_p)
    ) u_ram (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (w_ram_wdata),
        .addr_i  (w_ram_addr),
        .v_i     (w_ram_v),
        .w_i     (!r_v_i),
        .data_o  (w_ram_rdata)
    );

    // Select resets to 1 with zero data so the output reads 0 straight out of reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_fwd_sel  <= 1'b1;
            r_fwd_data <= '0;
        end else if (r_v_i) begin
            r_fwd_sel <= w_r_match;
            if (w_r_match) r_fwd_data <= w_r_fwd_data;
        end
    end

    assign w_read_data = r_fwd_sel ? r_fwd_data : w_ram_rdata;

    if (latch_last_read_p != 0) begin : g_latch
        logic               r_read_last;
        logic [width_p-1:0] r_hold;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                r_read_last <= 1'b0;
                r_hold      <= '0;
            end else begin
                r_read_last <= r_v_i;
                r_hold      <= r_data_o;
            end
        end

        assign r_data_o = r_read_last ? w_read_data : r_hold;
    end else begin : g_no_latch
        assign r_data_o = w_read_data;
    end

    // Counts consecutive cycles of a refused write; saturates once it reaches 2^16.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stall_cnt <= '0;
        end else if (w_v_i && !w_ready_o) begin
            if (!r_stall_cnt[16]) r_stall_cnt <= r_stall_cnt + 1'b1;
        end else begin
            r_stall_cnt <= '0;
        end
    end

    a_r_addr: assert property (@(posedge clk_i) disable iff (reset_i) r_v_i |-> (32'(r_addr_i) < els_p));
    a_w_addr: assert property (@(posedge clk_i) disable iff (reset_i) w_v_i |-> (32'(w_addr_i) < els_p));
    a_w_stall: assert property (@(posedge clk_i) disable iff (reset_i) !r_stall_cnt[16])
        else $warning("write held off for 2^16 cycles by continuous reads");

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_from_1rw.sv
// Scoreboard bench: read expectations are queued at issue, a monitor checks r_data_o one cycle later.
module tb_bsg_mem_1r1w_sync_from_1rw;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       w_v_i;
    logic [3:0] w_addr_i;
    logic [7:0] w_data_i;
    logic       w_ready_o;
    logic       r_v_i;
    logic [3:0] r_addr_i;
    logic [7:0] r_data_o;
    logic       wbuf_empty_o;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];
    int         rd_id = 0;

    always #5 clk = ~clk;

    bsg_mem_1r1w_sync_from_1rw #(
        .width_p           (8),
        .els_p             (16),
        .wbuf_els_p        (2),
        .latch_last_read_p (0),
        .harden_p          (0)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .w_v_i        (w_v_i),
        .w_addr_i     (w_addr_i),
        .w_data_i     (w_data_i),
        .w_ready_o    (w_ready_o),
        .r_v_i        (r_v_i),
        .r_addr_i     (r_addr_i),
        .r_data_o     (r_data_o),
        .wbuf_empty_o (wbuf_empty_o)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus after the falling edge; queue the expected read data.
    task automatic step(input logic wv, input logic [3:0] wa, input logic [7:0] wd,
                        input logic rv, input logic [3:0] ra, input logic [7:0] rexp);
        @(negedge clk);
        w_v_i    = wv;
        w_addr_i = wa;
        w_data_i = wd;
        r_v_i    = rv;
        r_addr_i = ra;
        if (rv) exp_q.push_back(rexp);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
    endtask

    // Monitor: a read sampled at a rising edge has its data checked shortly after that edge.
    always @(posedge clk) begin
        logic rd_now;
        rd_now = r_v_i;
        #2;
        if (rd_now && !reset_i) begin
            rd_id++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd%0d: got %h with no expected value queued", rd_id, r_data_o);
            end else begin
                check($sformatf("rd%0d", rd_id), r_data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_i  = 1'b1;
        w_v_i    = 1'b0;
        w_addr_i = '0;
        w_data_i = '0;
        r_v_i    = 1'b0;
        r_addr_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("reset_rdata", r_data_o, 8'h00);
        check("reset_ready", {7'd0, w_ready_o}, 8'd1);
        check("reset_empty", {7'd0, wbuf_empty_o}, 8'd1);

        // Direct writes into an empty buffer with no read competing.
        step(1'b1, 4'd0, 8'h5A, 1'b0, 4'd0, 8'h00);
        check("direct_ready", {7'd0, w_ready_o}, 8'd1);
        step(1'b1, 4'd7, 8'h00, 1'b0, 4'd0, 8'h00);
        step(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 8'h00);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'hA5);
        check("direct_empty", {7'd0, wbuf_empty_o}, 8'd1);

        // Two buffered writes to addr 5 under reads, third refused, youngest forwarded.
        step(1'b1, 4'd5, 8'h11, 1'b1, 4'd0, 8'h5A);
        check("buf1_ready", {7'd0, w_ready_o}, 8'd1);
        step(1'b1, 4'd5, 8'h22, 1'b1, 4'd0, 8'h5A);
        check("buf2_ready", {7'd0, w_ready_o}, 8'd1);
        check("buf2_empty", {7'd0, wbuf_empty_o}, 8'd0);
        step(1'b1, 4'd5, 8'h33, 1'b1, 4'd5, 8'h22);
        check("full_ready", {7'd0, w_ready_o}, 8'd0);
        idle();
        check("drain1_empty", {7'd0, wbuf_empty_o}, 8'd0);
        idle();
        check("drain2_empty", {7'd0, wbuf_empty_o}, 8'd0);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 8'h22);
        check("drained_empty", {7'd0, wbuf_empty_o}, 8'd1);

        // Same-cycle write and read of addr 7 returns the old value.
        step(1'b1, 4'd7, 8'h3C, 1'b1, 4'd7, 8'h00);
        check("rw_same_ready", {7'd0, w_ready_o}, 8'd1);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 8'h3C);
        check("rw_same_empty", {7'd0, wbuf_empty_o}, 8'd0);
        idle();

        // Full buffer, no read: drain and push in one cycle, count stays at 2.
        step(1'b1, 4'd8, 8'h81, 1'b1, 4'd0, 8'h5A);
        check("fill_empty", {7'd0, wbuf_empty_o}, 8'd1);
        step(1'b1, 4'd9, 8'h91, 1'b1, 4'd0, 8'h5A);
        step(1'b1, 4'd10, 8'hA1, 1'b0, 4'd0, 8'h00);
        check("full_noread_ready", {7'd0, w_ready_o}, 8'd1);
        step(1'b1, 4'd11, 8'hB1, 1'b1, 4'd10, 8'hA1);
        check("still_full_ready", {7'd0, w_ready_o}, 8'd0);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 8'h91);
        idle();
        idle();
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd8, 8'h81);
        check("final_drain_empty", {7'd0, wbuf_empty_o}, 8'd1);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd10, 8'hA1);
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 8'h91);

`ifdef BSG_MEM_WBUF_COALESCE_EN
        // Full buffer holding addr 9 absorbs another write to addr 9 in place.
        step(1'b1, 4'd9, 8'h10, 1'b1, 4'd0, 8'h5A);
        step(1'b1, 4'd12, 8'h20, 1'b1, 4'd0, 8'h5A);
        step(1'b1, 4'd9, 8'h77, 1'b1, 4'd12, 8'h20);
        check("coal_ready", {7'd0, w_ready_o}, 8'd1);
        step(1'b1, 4'd13, 8'hD1, 1'b1, 4'd9, 8'h77);
        check("coal_no_alloc", {7'd0, w_ready_o}, 8'd0);
        idle();
        idle();
        step(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 8'h77);
        check("coal_empty", {7'd0, wbuf_empty_o}, 8'd1);
`endif

        idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_queue: %0d reads never answered, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_mem_1r1w_sync_from_1rw.md
Name: bsg_mem_1r1w_sync_from_1rw

Overview:
- Emulates a 1R1W synchronous memory using a single-ported 1RW synchronous RAM (bsg_mem_1rw_sync) plus a small write buffer.
- Reads always win the RAM port. Writes park in the buffer and drain to RAM on cycles with no read.
- Reads to addresses with buffered writes are forwarded from the buffer.
- Intended for ASIC SRAM generators and FPGAs that only provide 1RW macros.

Parameters:
- width_p, none (required), data width in bits.
- els_p, none (required), number of words; addr_width_lp = BSG_SAFE_CLOG2(els_p).
- wbuf_els_p, 2, write-buffer entries; must be at least 1.
- latch_last_read_p, 0, when 1, r_data_o holds its value across cycles with no read.
- harden_p, 0, passed through to the 1RW RAM.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- w_v_i  in  1  write request.
- w_addr_i  in  addr_width_lp  write address.
- w_data_i  in  width_p  write data.
- w_ready_o  out  1  write accepted this cycle when w_v_i & w_ready_o.
- r_v_i  in  1  read request; always accepted.
- r_addr_i  in  addr_width_lp  read address.
- r_data_o  out  width_p  read data, valid in the cycle after r_v_i.
- wbuf_empty_o  out  1  buffer empty; all accepted writes are in RAM.

Behaviour:
- Reset (async):
  - buffer emptied; head, tail and count = 0.
  - w_ready_o = 1, wbuf_empty_o = 1.
  - r_data_o = 0: the forward-select flop resets to 1 and the forward-data flop resets to 0.
- RAM port arbitration, each cycle:
  - r_v_i=1: RAM read of r_addr_i.
  - else buffer non-empty: RAM write of the head entry; head pops.
  - else w_v_i=1 with buffer empty: the incoming write goes straight to RAM with no allocation.
  - else idle.
- Write accept:
  - w_ready_o = ~full | (~r_v_i & non-empty). A drain this cycle frees the head slot, so a same-cycle push is allowed when full.
  - An accepted write that does not go direct to RAM pushes {w_addr_i, w_data_i} at the tail.
- Read lookup: r_addr_i is compared (CAM) against all valid entries present at the clock edge.
  - Youngest match: its data is registered into the forward register, forward_sel_r = 1, and the RAM is still read (harmless).
  - No match: forward_sel_r = 0.
  - r_data_o = forward_sel_r ? forward_data_r : RAM output.
- Same-cycle read and write to the same address: the read returns the pre-write value. The incoming write is not visible until the following cycle.
- Entry leaving buffer while being read: a read matching only the head while that head drains in the same cycle cannot occur, because reads block draining.
- Ordering: the buffer is FIFO and drains oldest first, so the RAM always converges to program-order last write. wbuf_empty_o = (count==0).
- Sustained reads stall draining indefinitely. When full, w_ready_o = 0 until a read-free cycle.
- latch_last_read_p=1: cycles without r_v_i hold r_data_o at its last value.
- latch_last_read_p=0: r_data_o is unspecified (RAM output) on cycles following a cycle with no read.
- Simulation assertions: addresses < els_p; w_v_i is not held high with w_ready_o low for more than 2^16 cycles (warning only).

Optional Feature:
- Macro BSG_MEM_WBUF_COALESCE_EN.
- Defined:
  - an accepted write whose address matches a valid buffered entry overwrites that entry's data in place; no allocation.
  - w_ready_o is 1 on any address match, even when full.
  - at most one entry exists per address.
- Undefined: every buffered write allocates a new entry; duplicate addresses are allowed and resolved by the youngest-match rule.

Decomposition:
- No shared package needed.
- Entry layout {addr, data} and the full/empty/count widths are local, derived from wbuf_els_p via BSG_SAFE_CLOG2.
- One sub-module: bsg_mem_1r1w_sync_from_1rw_wbuf.
  - Holds the FIFO storage, head/tail pointers, and the youngest-match CAM with its forwarded-data output.
  - Holds the coalesce logic under the macro.
- The top level holds arbitration, the RAM instance, the forward registers and the latch_last_read logic.

Test Plan (width_p=8, els_p=16, wbuf_els_p=2):
- Reset then idle → r_data_o=0, w_ready_o=1, wbuf_empty_o=1.
- Write addr 3 = 0xA5 with no read, then read addr 3 → write goes direct to RAM; r_data_o=0xA5 the cycle after the read.
- Writes to addr 5 = 0x11 and then 0x22 in two cycles, each with a concurrent read of addr 0 → both buffered, w_ready_o=0 on the third write. Read of addr 5 next → 0x22 (youngest match). The first read-free cycle drains 0x11, the next drains 0x22; wbuf_empty_o=1 afterwards.
- Same cycle: write addr 7 = 0x3C and read addr 7 (old value 0x00) → r_data_o=0x00. A read one cycle later → 0x3C.
- Full buffer, no read, w_v_i=1 → w_ready_o=1; head drains and new entry pushes in the same cycle; count stays 2.
- With BSG_MEM_WBUF_COALESCE_EN: a full buffer holding addr 9 accepts a write to addr 9 = 0x77 → w_ready_o=1, no allocation, and a read of addr 9 returns 0x77.
